// File: rtl/vec_pkg.sv
// vec_pkg: opcodes, issue FSM states and opcode legality shared by the issue queue.
package vec_pkg;
  typedef enum logic [3:0] {
    e_add = 4'h0, e_sub = 4'h1, e_mul = 4'h2, e_fma = 4'h3,
    e_sadd = 4'h4, e_ssub = 4'h5, e_smul = 4'h6,
    e_read = 4'h8, e_write = 4'h9
  } op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {e_add, e_sub, e_mul, e_fma, e_sadd, e_ssub, e_smul, e_read, e_write};
  endfunction
endpackage

// File: rtl/vec_instr_fifo.sv
// vec_instr_fifo: circular FIFO; wrap-bit pointers distinguish full from empty.
module vec_instr_fifo #(
  parameter int width_p = 36,
  parameter int els_p = 4,
  localparam int pw_lp = $clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  logic [width_p-1:0] mem_r [els_p];
  logic [pw_lp:0] wp_r, rp_r;
  logic enq;
  assign empty_o = wp_r == rp_r;
  assign full_o = (wp_r[pw_lp] != rp_r[pw_lp]) && (wp_r[pw_lp-1:0] == rp_r[pw_lp-1:0]);
  assign enq = v_i && !full_o;
  assign data_o = mem_r[rp_r[pw_lp-1:0]];
  always_ff @(posedge clk_i) if (enq) mem_r[wp_r[pw_lp-1:0]] <= data_i;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wp_r <= '0;
      rp_r <= '0;
    end else begin
      if (enq) wp_r <= wp_r + (pw_lp+1)'(1);
      if (yumi_i) rp_r <= rp_r + (pw_lp+1)'(1);
    end
endmodule

// File: rtl/vec_issue_queue.sv
// vec_issue_queue: buffers packed vector instructions, drops illegal opcodes and
// issues one at a time, waiting for the unit's done before the next.
module vec_issue_queue import vec_pkg::*; #(
  parameter int els_p = 8,
  parameter int vlen_p = 4,
  parameter int vdw_p = 4,
  parameter int fifo_els_p = 4,
  localparam int aw_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int wd_lp = vlen_p * vdw_p,
  localparam int instr_width_lp = 4 + 4*aw_lp + vdw_p + wd_lp
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [instr_width_lp-1:0] instr_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic [3:0]                op_o,
  output logic [aw_lp-1:0]          addrA_o,
  output logic [aw_lp-1:0]          addrB_o,
  output logic [aw_lp-1:0]          addrC_o,
  output logic [aw_lp-1:0]          addrD_o,
  output logic [vdw_p-1:0]          scalar_o,
  output logic [wd_lp-1:0]          w_data_o,
  output logic                      issue_v_o,
  input  logic                      unit_ready_i,
  input  logic                      unit_done_i,
  output logic                      busy_o,
  output logic                      illegal_o,
  output logic [15:0]               issued_count_o
);
  logic [instr_width_lp-1:0] head;
  logic full, empty, legal, pop;
  state_e state_r, state_n;
  vec_instr_fifo #(.width_p(instr_width_lp), .els_p(fifo_els_p)) fifo (
    .clk_i, .reset_n_i, .data_i(instr_i), .v_i, .yumi_i(pop),
    .data_o(head), .full_o(full), .empty_o(empty)
  );
  assign legal = is_legal_op(head[instr_width_lp-1 -: 4]);
  // Illegal heads are discarded even while the unit is not ready.
  assign pop = state_r == IDLE && !empty && (!legal || unit_ready_i);
  assign ready_o = !full;
  assign issue_v_o = state_r == ISSUE;
  assign busy_o = state_r != IDLE || !empty;
  always_comb
    state_n = state_r == IDLE  ? ((!empty && legal && unit_ready_i) ? ISSUE : IDLE) :
              state_r == ISSUE ? WAIT :
              (unit_done_i ? IDLE : WAIT);
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= IDLE;
      {op_o, addrD_o, addrA_o, addrB_o, addrC_o, scalar_o, w_data_o} <= '0;
      issued_count_o <= '0;
      illegal_o <= 1'b0;
    end else begin
      state_r <= state_n;
      if (pop && legal) {op_o, addrD_o, addrA_o, addrB_o, addrC_o, scalar_o, w_data_o} <= head;
      if (issue_v_o) issued_count_o <= issued_count_o + 16'd1;
      if (pop && !legal) illegal_o <= 1'b1;
    end
endmodule

// File: tb/tb_vec_issue_queue.sv
// tb_vec_issue_queue: scoreboarded bench for the vector issue queue.
module tb_vec_issue_queue;
  logic clk = 1'b0, reset_n = 1'b1, v = 1'b0, unit_ready = 1'b1, unit_done = 1'b0;
  logic [35:0] instr = '0;
  logic ready, issue_v, busy, illegal;
  logic [3:0] op, scalar;
  logic [2:0] addr_a, addr_b, addr_c, addr_d;
  logic [15:0] w_data, issued_count;
  logic [35:0] fields;
  int checks = 0, errors = 0, n_issue = 0;
  logic [35:0] sb[$];
  vec_issue_queue dut (
    .clk_i(clk), .reset_n_i(reset_n), .instr_i(instr), .v_i(v), .ready_o(ready),
    .op_o(op), .addrA_o(addr_a), .addrB_o(addr_b), .addrC_o(addr_c), .addrD_o(addr_d),
    .scalar_o(scalar), .w_data_o(w_data), .issue_v_o(issue_v),
    .unit_ready_i(unit_ready), .unit_done_i(unit_done), .busy_o(busy),
    .illegal_o(illegal), .issued_count_o(issued_count)
  );
  always #5 clk = ~clk;
  assign fields = {op, addr_d, addr_a, addr_b, addr_c, scalar, w_data};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] mk(input logic [3:0] o, input logic [2:0] d, a, b, c,
                                     input logic [3:0] s, input logic [15:0] w);
    return {o, d, a, b, c, s, w};
  endfunction
  always @(negedge clk)
    if (issue_v) begin
      n_issue++;
      check("issue_expected", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) check("issue_fields", 64'(fields), 64'(sb.pop_front()));
    end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic push(input logic [35:0] ins, input bit legal, output bit acc);
    instr = ins;
    v = 1'b1;
    acc = ready;
    if (acc && legal) sb.push_back(ins);
    tick;
    v = 1'b0;
  endtask
  task automatic done_pulse;
    unit_done = 1'b1;
    tick;
    unit_done = 1'b0;
  endtask
  task automatic wait_issue(input string tag, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick;
      seen = issue_v;
    end
    check(tag, 64'(seen), 1);
  endtask
  initial begin
    bit acc;
    int c;
    logic [35:0] ins;
    logic [15:0] c0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_ready", 64'(ready), 1);
    check("rst_issue", 64'(issue_v), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_illegal", 64'(illegal), 0);
    check("rst_count", 64'(issued_count), 0);
    check("rst_fields", 64'(fields), 0);
    tick;
    reset_n = 1'b1;
    tick;
    // write then read
    push(mk(4'h9, 3'd4, 3'd0, 3'd0, 3'd0, 4'h0, 16'h1122), 1'b1, acc);
    check("t1_acc", 64'(acc), 1);
    push(mk(4'h8, 3'd0, 3'd4, 3'd0, 3'd0, 4'h0, 16'h0000), 1'b1, acc);
    check("t1_issue_latency", 64'(issue_v), 1);
    check("t1_op", 64'(op), 9);
    check("t1_addrD", 64'(addr_d), 4);
    check("t1_wdata", 64'(w_data), 64'h1122);
    repeat (4) tick;
    check("t1_held", 64'(n_issue), 1);
    check("t1_busy", 64'(busy), 1);
    done_pulse;
    wait_issue("t1_second", 3);
    tick;
    check("t1_count", 64'(issued_count), 2);
    done_pulse;
    repeat (2) tick;
    check("t1_idle", 64'(busy), 0);
    // fma decode held through WAIT
    ins = mk(4'h3, 3'd7, 3'd4, 3'd5, 3'd6, 4'h2, 16'habcd);
    push(ins, 1'b1, acc);
    wait_issue("t2_issue", 3);
    repeat (5) begin
      tick;
      check("t2_hold", 64'(fields), 64'(ins));
      check("t2_no_reissue", 64'(issue_v), 0);
    end
    done_pulse;
    tick;
    // full fifo: 1 in flight + 4 queued
    c = n_issue;
    for (int i = 0; i < 5; i++) begin
      push(mk(4'h0, 3'(i), 3'(i), 3'(i), 3'(i), 4'(i), 16'(i*3+1)), 1'b1, acc);
      check("t3_acc", 64'(acc), 1);
    end
    check("t3_full_ready", 64'(ready), 0);
    push(mk(4'h1, 3'd7, 3'd7, 3'd7, 3'd7, 4'h7, 16'hdead), 1'b1, acc);
    check("t3_reject", 64'(acc), 0);
    check("t3_in_flight", 64'(n_issue - c), 1);
    done_pulse;
    check("t3_still_full", 64'(ready), 0);
    tick;
    check("t3_ready_back", 64'(ready), 1);
    check("t3_issue2", 64'(issue_v), 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      done_pulse;
      wait_issue("t3_drain", 3);
    end
    tick;
    done_pulse;
    tick;
    check("t3_count", 64'(issued_count), 8);
    check("t3_sb_empty", 64'(sb.size()), 0);
    check("t3_idle", 64'(busy), 0);
    // illegal opcode dropped
    c0 = issued_count;
    push(mk(4'hf, 3'd1, 3'd2, 3'd3, 3'd4, 4'h5, 16'h0006), 1'b0, acc);
    push(mk(4'h0, 3'd1, 3'd2, 3'd3, 3'd4, 4'h5, 16'h0f0f), 1'b1, acc);
    check("t4_illegal_set", 64'(illegal), 1);
    wait_issue("t4_add", 3);
    tick;
    check("t4_count", 64'(issued_count), 64'(c0 + 16'd1));
    done_pulse;
    tick;
    check("t4_sticky", 64'(illegal), 1);
    // back-pressure
    unit_ready = 1'b0;
    push(mk(4'h2, 3'd1, 3'd1, 3'd2, 3'd3, 4'h4, 16'h1234), 1'b1, acc);
    push(mk(4'h5, 3'd2, 3'd3, 3'd4, 3'd5, 4'h9, 16'h5678), 1'b1, acc);
    repeat (10) begin
      tick;
      check("t5_no_issue", 64'(issue_v), 0);
    end
    check("t5_busy", 64'(busy), 1);
    unit_ready = 1'b1;
    wait_issue("t5_resume", 1);
    tick;
    done_pulse;
    wait_issue("t5_second", 3);
    tick;
    done_pulse;
    tick;
    // reset while waiting with two queued
    for (int i = 0; i < 3; i++) push(mk(4'h1, 3'(i), 3'd1, 3'd2, 3'd3, 4'h1, 16'(i)), 1'b1, acc);
    tick;
    check("t6_busy", 64'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("t6_ready", 64'(ready), 1);
    check("t6_issue", 64'(issue_v), 0);
    check("t6_busy_rst", 64'(busy), 0);
    check("t6_fields", 64'(fields), 0);
    check("t6_count", 64'(issued_count), 0);
    check("t6_illegal", 64'(illegal), 0);
    sb.delete();
    c = n_issue;
    tick;
    reset_n = 1'b1;
    repeat (5) tick;
    check("t6_no_issue", 64'(n_issue - c), 0);
    push(mk(4'h6, 3'd5, 3'd6, 3'd7, 3'd1, 4'h3, 16'hbeef), 1'b1, acc);
    wait_issue("t6_new", 3);
    tick;
    check("t6_count_new", 64'(issued_count), 1);
    done_pulse;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
